uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter TIMEOUT_CYC, default 200000: maximum CLK cycles allowed per byte, measured from TX_START to TX_DONE.
REQ-003 CLK  input  1  single system clock; all logic on its rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 REQ  input  N_REQ  per-requester byte request; level, held until the matching ACK.
REQ-006 REQ_DATA  input  8*N_REQ  packed bytes; requester i at [8i+7:8i]; stable while REQ[i]=1.
REQ-007 ACK  output  N_REQ  one-hot, one-cycle pulse: byte of requester i fully transmitted.
REQ-008 TX_START  output  1  one-cycle start pulse to the transmitter.
REQ-009 TX_DATA  output  8  byte to transmit; registered.
REQ-010 TX_BUSY  input  1  transmitter busy flag.
REQ-011 TX_DONE  input  1  one-cycle pulse: transmitter finished the stop bit.
REQ-012 OWNER  output  clog2(N_REQ)  index of the current or last granted requester.
REQ-013 TIMEOUT_ERR  output  1  sticky flag: a transfer was aborted on timeout.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT_BUSY and WAIT_DONE; all outputs SHALL be registered.
REQ-015 In IDLE, when any eligible REQ bit is 1, the next edge SHALL:
- select the winner round-robin, searching from (OWNER+1) mod N_REQ upward with wrap;
- load OWNER and latch TX_DATA from the winner's byte;
- drive TX_START=1 for exactly that cycle;
- enter WAIT_BUSY.
REQ-016 Latency SHALL be 1 cycle from REQ sampled in IDLE to TX_START high.
REQ-017 TX_DATA and OWNER SHALL hold from TX_START until the FSM returns to IDLE.
REQ-018 WAIT_BUSY SHALL move to WAIT_DONE on TX_BUSY=1, or directly to IDLE with ACK if TX_DONE=1 is seen in WAIT_BUSY.
REQ-019 WAIT_DONE SHALL stay until TX_DONE=1. On that edge it SHALL pulse ACK[OWNER] for one cycle and return to IDLE.
REQ-020 In the IDLE cycle where ACK is high, REQ[OWNER] SHALL be ineligible, so a stale request is never re-granted. Other requesters SHALL be arbitrated in that same cycle.
REQ-021 A cycle counter SHALL clear on TX_START and increment in WAIT_BUSY and WAIT_DONE. When it reaches TIMEOUT_CYC-1, the block SHALL:
- set TIMEOUT_ERR;
- return to IDLE with no ACK;
- keep OWNER, so the next search starts past the failed requester.
REQ-022 Counter width SHALL be clog2(TIMEOUT_CYC)+1. The counter SHALL saturate and never wrap.
REQ-023 Requests dropped before ACK SHALL not affect an in-flight transfer, which SHALL complete and still ACK.
REQ-024 TX_DONE or TX_BUSY seen in IDLE SHALL be ignored.
REQ-025 REQ bits at index ≥ N_REQ do not exist; requests while not in IDLE SHALL only be sampled on return to IDLE.

Reset
REQ-026 While RST=0, asynchronously: state=IDLE, ACK=0, TX_START=0, TX_DATA=8'h00, counter=0, TIMEOUT_ERR=0, and OWNER=N_REQ-1, so the first search starts at requester 0.
REQ-027 Reset during WAIT_BUSY or WAIT_DONE SHALL abort the transfer with no ACK. The first grant after RST release SHALL take ≥1 cycle.
REQ-028 TIMEOUT_ERR SHALL clear only by reset.

Structure
REQ-029 State encoding and the data width constant (8) SHALL live in the shared package uart_pkg.
REQ-030 The round-robin winner search SHALL be a combinational sub-module uart_rr_pick with inputs request vector, mask and last owner, and outputs valid and index.

Verification (N_REQ=4, TIMEOUT_CYC=16)
REQ-031 Single request:
- stimulus: REQ=4'b0100, byte 8'hA5; TX_BUSY 2 cycles after TX_START; TX_DONE 10 cycles later;
- response: TX_START 1 cycle after REQ, TX_DATA=8'hA5, OWNER=2, ACK=4'b0100 for one cycle.
REQ-032 Fairness:
- stimulus: REQ=4'b1111 held, each requester re-requesting after its ACK, bytes 8'h10..8'h13;
- response: grant order 0,1,2,3,0 with TX_DATA sequence 8'h10,11,12,13,10.
REQ-033 Stale request:
- stimulus: requester 1 drops REQ only one cycle after ACK; REQ[3]=1;
- response: next grant is 3 and requester 1 is not re-granted.
REQ-034 Timeout:
- stimulus: REQ=4'b0001, TX_BUSY=1, TX_DONE never;
- response: 16 cycles after TX_START, TIMEOUT_ERR=1, no ACK, FSM in IDLE; next grant to REQ[0] proceeds normally.
REQ-035 Reset in WAIT_DONE:
- stimulus: RST=0 for 1 cycle while in WAIT_DONE;
- response: all outputs at reset values immediately, no ACK; after release with REQ=4'b1000, OWNER=3.
REQ-036 Early TX_DONE: TX_DONE pulse in WAIT_BUSY -> ACK issued and FSM returns to IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: byte width and FSM state encoding.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester and transmitter signals of the UART arbiter; master is the arbiter side.
interface uart_tx_arb_if #(
  parameter int N_REQ = 4
) ();
  import uart_pkg::*;

  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req;
  logic [DATA_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]        ack;
  logic                    tx_start;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_busy;
  logic                    tx_done;
  logic [IDX_W-1:0]        owner;
  logic                    timeout_err;

  modport master (
    input  req, req_data, tx_busy, tx_done,
    output ack, tx_start, tx_data, owner, timeout_err
  );

  modport slave (
    output req, req_data, tx_busy, tx_done,
    input  ack, tx_start, tx_data, owner, timeout_err
  );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin search: first eligible request after the last owner, with wrap.
module uart_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [N_REQ-1:0] elig;
  logic [IDX_W-1:0] cand;

  assign elig = req & ~mask;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    // Offset 1..N_REQ so the last owner is considered only after everyone else.
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(last) + k) % N_REQ);
      if (!valid && elig[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte requesters, with per-byte timeout.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_arb_if.master bus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic              pick_vld;
  logic [IDX_W-1:0]  pick_idx;
  logic [DATA_W-1:0] pick_byte;

  // ack is only non-zero in the IDLE cycle right after completion, so it doubles
  // as the mask that keeps the just-served requester from being re-granted.
  uart_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (bus.req),
    .mask  (bus.ack),
    .last  (bus.owner),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) pick_byte = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      bus.ack         <= '0;
      bus.tx_start    <= 1'b0;
      bus.tx_data     <= '0;
      bus.owner       <= IDX_W'(N_REQ - 1);
      bus.timeout_err <= 1'b0;
      cnt             <= '0;
    end else begin
      bus.ack      <= '0;
      bus.tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            state        <= ST_WAIT_BUSY;
            bus.owner    <= pick_idx;
            bus.tx_data  <= pick_byte;
            bus.tx_start <= 1'b1;
            cnt          <= '0;
          end
        end
        ST_WAIT_BUSY, ST_WAIT_DONE: begin
          // A completed byte wins over a timeout landing on the same edge.
          if (bus.tx_done) begin
            bus.ack[bus.owner] <= 1'b1;
            state              <= ST_IDLE;
          end else if (cnt == CNT_LAST) begin
            bus.timeout_err <= 1'b1;
            state           <= ST_IDLE;
          end else if (state == ST_WAIT_BUSY && bus.tx_busy) begin
            state <= ST_WAIT_DONE;
          end
          if (cnt != '1) cnt <= cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb (N_REQ=4, TIMEOUT_CYC=16): vector table plus hand sequences.
module tb_uart_tx_arb;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  uart_tx_arb_if #(.N_REQ(4)) bus ();

  uart_tx_arb #(
    .N_REQ       (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       busy;
    logic       done;
    logic       start;
    logic [3:0] ack;
    logic [1:0] own;
    logic [7:0] data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [3:0] r, logic b, logic d,
                              logic s, logic [3:0] a, logic [1:0] o, logic [7:0] dt);
    vec_t v;
    v.req = r; v.busy = b; v.done = d;
    v.start = s; v.ack = a; v.own = o; v.data = dt;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic reset_pulse(input string nm, input int cycles);
    rst_n = 1'b0;
    #1;
    chk({nm, " rst ack"},   32'(bus.ack), 32'd0);
    chk({nm, " rst start"}, 32'(bus.tx_start), 32'd0);
    chk({nm, " rst data"},  32'(bus.tx_data), 32'd0);
    chk({nm, " rst owner"}, 32'(bus.owner), 32'd3);
    chk({nm, " rst err"},   32'(bus.timeout_err), 32'd0);
    repeat (cycles) tick();
    chk({nm, " rst ack held"}, 32'(bus.ack), 32'd0);
    rst_n = 1'b1;
  endtask

  // Grant on the next edge, then busy one cycle, then done; checks grant and ack.
  task automatic xfer(input logic [1:0] own, input logic [7:0] dat,
                      input logic [3:0] req_after, input string nm);
    tick();
    chk({nm, " start"}, 32'(bus.tx_start), 32'd1);
    chk({nm, " owner"}, 32'(bus.owner), 32'(own));
    chk({nm, " data"},  32'(bus.tx_data), 32'(dat));
    bus.req     = req_after;
    bus.tx_busy = 1'b1;
    tick();
    chk({nm, " no early ack"}, 32'(bus.ack), 32'd0);
    bus.tx_busy = 1'b0;
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    chk({nm, " ack"}, 32'(bus.ack), 32'(4'b0001 << own));
  endtask

  initial begin
    int own_seq[5];
    checks = 0;
    errors = 0;
    own_seq = '{0, 1, 2, 3, 0};
    rst_n        = 1'b1;
    bus.req      = '0;
    bus.req_data = {8'h13, 8'hA5, 8'h11, 8'h10};
    bus.tx_busy  = 1'b0;
    bus.tx_done  = 1'b0;
    tick();
    reset_pulse("init", 3);

    // Single request to 2, early-done transfers, and TX_BUSY/TX_DONE ignored in IDLE.
    vecs.push_back(mk(4'b0100, 0, 0, 1, 4'b0000, 2, 8'hA5));
    vecs.push_back(mk(4'b0100, 0, 0, 0, 4'b0000, 2, 8'hA5));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(4'b0100, 1, 0, 0, 4'b0000, 2, 8'hA5));
    vecs.push_back(mk(4'b0100, 0, 1, 0, 4'b0100, 2, 8'hA5));
    vecs.push_back(mk(4'b0000, 0, 0, 0, 4'b0000, 2, 8'hA5));
    vecs.push_back(mk(4'b0001, 0, 0, 1, 4'b0000, 0, 8'h10));
    vecs.push_back(mk(4'b0001, 0, 1, 0, 4'b0001, 0, 8'h10));
    vecs.push_back(mk(4'b0000, 0, 0, 0, 4'b0000, 0, 8'h10));
    vecs.push_back(mk(4'b0000, 1, 1, 0, 4'b0000, 0, 8'h10));
    vecs.push_back(mk(4'b0000, 0, 0, 0, 4'b0000, 0, 8'h10));
    vecs.push_back(mk(4'b0100, 0, 0, 1, 4'b0000, 2, 8'hA5));
    vecs.push_back(mk(4'b0100, 0, 1, 0, 4'b0100, 2, 8'hA5));
    vecs.push_back(mk(4'b0000, 0, 0, 0, 4'b0000, 2, 8'hA5));

    for (int i = 0; i < vecs.size(); i++) begin
      bus.req     = vecs[i].req;
      bus.tx_busy = vecs[i].busy;
      bus.tx_done = vecs[i].done;
      tick();
      chk($sformatf("v%0d start", i), 32'(bus.tx_start), 32'(vecs[i].start));
      chk($sformatf("v%0d ack", i),   32'(bus.ack), 32'(vecs[i].ack));
      chk($sformatf("v%0d owner", i), 32'(bus.owner), 32'(vecs[i].own));
      chk($sformatf("v%0d data", i),  32'(bus.tx_data), 32'(vecs[i].data));
      chk($sformatf("v%0d err", i),   32'(bus.timeout_err), 32'd0);
    end
    bus.tx_busy = 1'b0;
    bus.tx_done = 1'b0;

    // Fairness: all four requesting, each drops only in its own ACK cycle.
    bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req      = 4'b1111;
    reset_pulse("fair", 1);
    for (int i = 0; i < 5; i++) begin
      xfer(2'(own_seq[i]), 8'(8'h10 + own_seq[i]), 4'b1111, $sformatf("fair%0d", i));
      bus.req = 4'b1111 & ~(4'b0001 << own_seq[i]);
    end
    bus.req = 4'b0000;
    tick();
    chk("fair idle start", 32'(bus.tx_start), 32'd0);

    // Stale request: requester 1 keeps REQ through its ACK cycle.
    bus.req = 4'b1010;
    xfer(2'd1, 8'h11, 4'b1010, "stale r1");
    xfer(2'd3, 8'h13, 4'b1000, "stale r3");
    bus.req = 4'b0000;
    tick();
    chk("stale idle start", 32'(bus.tx_start), 32'd0);
    chk("stale idle owner", 32'(bus.owner), 32'd3);
    bus.req = 4'b0010;
    xfer(2'd1, 8'h11, 4'b0010, "lone r1");
    tick();
    chk("lone not regranted", 32'(bus.tx_start), 32'd0);
    bus.req = 4'b0000;
    tick();

    // Timeout: busy forever, never done.
    bus.req = 4'b0001;
    tick();
    chk("to start", 32'(bus.tx_start), 32'd1);
    chk("to owner", 32'(bus.owner), 32'd0);
    bus.tx_busy = 1'b1;
    for (int k = 1; k < 16; k++) begin
      tick();
      chk($sformatf("to c%0d err", k), 32'(bus.timeout_err), 32'd0);
      chk($sformatf("to c%0d ack", k), 32'(bus.ack), 32'd0);
    end
    tick();
    chk("to err set", 32'(bus.timeout_err), 32'd1);
    chk("to no ack",  32'(bus.ack), 32'd0);
    chk("to owner kept", 32'(bus.owner), 32'd0);
    bus.tx_busy = 1'b0;
    xfer(2'd0, 8'h10, 4'b0001, "after to");
    chk("to err sticky", 32'(bus.timeout_err), 32'd1);
    bus.req = 4'b0000;
    tick();

    // Reset while in WAIT_DONE.
    bus.req = 4'b0100;
    tick();
    chk("rwd start", 32'(bus.tx_start), 32'd1);
    chk("rwd owner", 32'(bus.owner), 32'd2);
    bus.tx_busy = 1'b1;
    tick();
    bus.tx_done = 1'b1;
    reset_pulse("rwd", 1);
    bus.tx_done = 1'b0;
    bus.tx_busy = 1'b0;
    bus.req     = 4'b1000;
    tick();
    chk("rwd regrant start", 32'(bus.tx_start), 32'd1);
    chk("rwd regrant owner", 32'(bus.owner), 32'd3);
    chk("rwd regrant data",  32'(bus.tx_data), 32'h13);
    chk("rwd regrant ack",   32'(bus.ack), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
